// File: rtl/inst_encoder_if.sv
// Field/handshake bundle between the boot loader front end and inst_encoder.
// master = loader side (drives instruction fields, consumes encoded words),
// slave  = encoder side.
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  // Field input side
  logic              i_valid;
  logic              o_ready;
  logic [2:0]        i_immType;
  logic [6:0]        i_opcode;
  logic [4:0]        i_rd;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [2:0]        i_funct3;
  logic [31:0]       i_imm;
  logic              i_addrLoad;
  logic [ADDR_W-1:0] i_addrVal;

  // Encoded word output side
  logic              o_valid;
  logic              i_ready;
  logic [31:0]       o_inst;
  logic [ADDR_W-1:0] o_addr;
  logic              o_immErr;
  logic [CNT_W-1:0]  o_errCnt;

  modport master (
    output i_valid, i_immType, i_opcode, i_rd, i_rs1, i_rs2, i_funct3,
           i_imm, i_addrLoad, i_addrVal, i_ready,
    input  o_ready, o_valid, o_inst, o_addr, o_immErr, o_errCnt
  );

  modport slave (
    input  i_valid, i_immType, i_opcode, i_rd, i_rs1, i_rs2, i_funct3,
           i_imm, i_addrLoad, i_addrVal, i_ready,
    output o_ready, o_valid, o_inst, o_addr, o_immErr, o_errCnt
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs decoded fields plus an immGen-style
// immediate back into a 32-bit instruction word, with range checking,
// one registered output stage and a running write address.
module inst_encoder #(
  parameter int unsigned           ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = ADDR_W'(32'h0000_0000),
  parameter int unsigned           CNT_W     = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  inst_encoder_if.slave bus
);

  // Immediate format codes
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [31:0] imm;
  logic [31:0] imm_keep;
  logic [31:0] inst_c;
  logic        err_c;
  logic        accept;
  logic        handshake;

  assign imm       = bus.i_imm;
  assign bus.o_ready = !bus.o_valid || bus.i_ready;
  assign accept    = bus.i_valid && bus.o_ready;
  assign handshake = bus.o_valid && bus.i_ready;

  // Range-check the immediate and scatter it into the format's bit positions;
  // an out-of-range immediate contributes no bits to the word.
  always_comb begin
    err_c    = 1'b0;
    imm_keep = imm;
    inst_c   = 32'h0;
    case (bus.i_immType)
      IMM_I: begin
        err_c    = !((&imm[31:11]) || !(|imm[31:11]));
        imm_keep = err_c ? 32'h0 : imm;
        inst_c   = {imm_keep[11:0], bus.i_rs1, bus.i_funct3, bus.i_rd,
                    bus.i_opcode};
      end
      IMM_S: begin
        err_c    = !((&imm[31:11]) || !(|imm[31:11]));
        imm_keep = err_c ? 32'h0 : imm;
        inst_c   = {imm_keep[11:5], bus.i_rs2, bus.i_rs1, bus.i_funct3,
                    imm_keep[4:0], bus.i_opcode};
      end
      IMM_B: begin
        err_c    = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
        imm_keep = err_c ? 32'h0 : imm;
        inst_c   = {imm_keep[12], imm_keep[10:5], bus.i_rs2, bus.i_rs1,
                    bus.i_funct3, imm_keep[4:1], imm_keep[11], bus.i_opcode};
      end
      IMM_U: begin
        err_c    = |imm[11:0];
        imm_keep = err_c ? 32'h0 : imm;
        inst_c   = {imm_keep[31:12], bus.i_rd, bus.i_opcode};
      end
      IMM_J: begin
        err_c    = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
        imm_keep = err_c ? 32'h0 : imm;
        inst_c   = {imm_keep[20], imm_keep[10:1], imm_keep[11],
                    imm_keep[19:12], bus.i_rd, bus.i_opcode};
      end
      default: begin
        err_c    = 1'b1;
        imm_keep = 32'h0;
        inst_c   = 32'h0;
      end
    endcase
  end

  // Output stage: load on accept, drop valid once the held word is taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid  <= 1'b0;
      bus.o_inst   <= 32'h0;
      bus.o_immErr <= 1'b0;
    end else if (accept) begin
      bus.o_valid  <= 1'b1;
      bus.o_inst   <= inst_c;
      bus.o_immErr <= err_c;
    end else if (handshake) begin
      bus.o_valid  <= 1'b0;
    end
  end

  // Write address: explicit load wins over the post-handshake advance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_addr <= BASE_ADDR;
    end else if (bus.i_addrLoad) begin
      bus.o_addr <= bus.i_addrVal;
    end else if (handshake) begin
      bus.o_addr <= bus.o_addr + ADDR_STEP;
    end
  end

  // Saturating count of errored words that actually left the encoder.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_errCnt <= '0;
    end else if (handshake && bus.o_immErr && (bus.o_errCnt != CNT_MAX)) begin
      bus.o_errCnt <= bus.o_errCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with hand-computed instruction words.
module tb_inst_encoder;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  inst_encoder_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  inst_encoder #(
    .ADDR_W   (32),
    .BASE_ADDR(32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm);
    bus.i_valid   = 1'b1;
    bus.i_immType = t;
    bus.i_opcode  = op;
    bus.i_rd      = rd;
    bus.i_rs1     = rs1;
    bus.i_rs2     = rs2;
    bus.i_funct3  = f3;
    bus.i_imm     = imm;
  endtask

  task automatic word(input string tag, input logic [31:0] inst,
                      input logic err, input logic [31:0] addr);
    check({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
    check({tag, ".inst"},  bus.o_inst, inst);
    check({tag, ".err"},   32'(bus.o_immErr), 32'(err));
    check({tag, ".addr"},  bus.o_addr, addr);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_addrLoad = 1'b0;
    bus.i_addrVal = 32'h0;
    drive(IMM_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
    bus.i_valid = 1'b0;
    #3;
    check("rst.valid", 32'(bus.o_valid), 32'd0);
    check("rst.inst",  bus.o_inst, 32'h0);
    check("rst.err",   32'(bus.o_immErr), 32'd0);
    check("rst.addr",  bus.o_addr, 32'h0);
    check("rst.cnt",   32'(bus.o_errCnt), 32'd0);
    check("rst.ready", 32'(bus.o_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;

    // addi x1,x2,-1
    drive(IMM_I, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF);
    tick();
    word("addi", 32'hFFF1_0093, 1'b0, 32'h0);
    bus.i_valid = 1'b0;
    tick();
    check("drain.valid", 32'(bus.o_valid), 32'd0);
    check("drain.addr",  bus.o_addr, 32'h4);

    // Reload address 0, then sw / beq back-to-back
    bus.i_addrLoad = 1'b1;
    bus.i_addrVal  = 32'h0;
    tick();
    bus.i_addrLoad = 1'b0;
    check("reload.addr", bus.o_addr, 32'h0);
    drive(IMM_S, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 32'h8);
    tick();
    word("sw", 32'h0051_2423, 1'b0, 32'h0);
    drive(IMM_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
    tick();
    word("beq", 32'hFE00_0EE3, 1'b0, 32'h4);
    drive(IMM_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
    tick();
    word("jal", 32'h0010_00EF, 1'b0, 32'h8);
    drive(IMM_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    tick();
    word("lui", 32'h1234_52B7, 1'b0, 32'hC);
    drive(IMM_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_F800);
    tick();
    word("imin", 32'h8000_0013, 1'b0, 32'h10);

    // Out-of-range immediates
    drive(IMM_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h3);
    tick();
    word("berr", 32'h0020_8063, 1'b1, 32'h14);
    drive(IMM_I, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'h800);
    tick();
    word("ierr", 32'h0002_0193, 1'b1, 32'h18);
    drive(IMM_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1001);
    tick();
    word("uerr", 32'h0000_02B7, 1'b1, 32'h1C);
    bus.i_valid = 1'b0;
    tick();
    check("err.cnt",  32'(bus.o_errCnt), 32'd3);
    check("err.addr", bus.o_addr, 32'h20);

    // Undefined format: word forced to zero
    drive(3'd7, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'h0);
    tick();
    word("undef", 32'h0, 1'b1, 32'h20);
    bus.i_valid = 1'b0;
    tick();
    check("undef.cnt", 32'(bus.o_errCnt), 32'd4);

    // Backpressure
    bus.i_ready = 1'b0;
    drive(IMM_I, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF);
    tick();
    word("bp0", 32'hFFF1_0093, 1'b0, 32'h24);
    drive(IMM_S, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 32'h8);
    check("bp.ready0", 32'(bus.o_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      word("bp.hold", 32'hFFF1_0093, 1'b0, 32'h24);
      check("bp.ready", 32'(bus.o_ready), 32'd0);
    end
    bus.i_ready = 1'b1;
    #1;
    check("bp.ready1", 32'(bus.o_ready), 32'd1);
    tick();
    word("bp1", 32'h0051_2423, 1'b0, 32'h28);
    bus.i_valid = 1'b0;
    tick();

    // Address load then async reset with a word held
    bus.i_addrLoad = 1'b1;
    bus.i_addrVal  = 32'h100;
    tick();
    bus.i_addrLoad = 1'b0;
    drive(IMM_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
    tick();
    word("load", 32'h0010_00EF, 1'b0, 32'h100);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst.valid", 32'(bus.o_valid), 32'd0);
    check("arst.addr",  bus.o_addr, 32'h0);
    check("arst.cnt",   32'(bus.o_errCnt), 32'd0);
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
